// File: rtl/multicycle_sequencer_pkg.sv
// Shared constants, state encoding and opcode classing
// for the multi-cycle control sequencer.
package multicycle_sequencer_pkg;

    localparam logic [3:0] OP_LW  = 4'b0000;
    localparam logic [3:0] OP_SW  = 4'b0001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_J   = 4'b1101;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_FUNC = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_ADD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        FAULT
    } state_t;

    typedef enum logic [2:0] {
        C_DP,
        C_LW,
        C_SW,
        C_BEQ,
        C_BNE,
        C_J
    } op_class_t;

    function automatic op_class_t op_class(
        input logic [3:0] op
    );
        op_class_t c;
        unique case (1'b1)
            (op == OP_LW):  c = C_LW;
            (op == OP_SW):  c = C_SW;
            (op == OP_BEQ): c = C_BEQ;
            (op == OP_BNE): c = C_BNE;
            (op == OP_J):   c = C_J;
            default:        c = C_DP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// Memory-ack wait timer: counts non-ack cycles and
// flags the last allowed one.
module seq_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] count;

    // Count waiting cycles; saturate at the last allowed one
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
// for the 8-bit datapath, with ack timeout and retire count.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int OPCODE_W     = 4,
    parameter int WAIT_MAX     = 15,
    parameter int RETIRE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [OPCODE_W-1:0]     opcode,
    input  logic                    zero,
    input  logic                    imem_ack,
    input  logic                    dmem_ack,
    output logic                    imem_req,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic [1:0]              pc_src,
    output logic [1:0]              alu_op,
    output logic                    alu_src,
    output logic                    reg_dst,
    output logic                    mem_to_reg,
    output logic                    reg_write,
    output logic                    dmem_read,
    output logic                    dmem_write,
    output logic                    busy,
    output logic                    fault,
    output logic [RETIRE_CNT_W-1:0] retired_count
);

    state_t              state;
    state_t              state_n;
    logic [OPCODE_W-1:0] op_q;
    op_class_t           cls;
    logic                waiting;
    logic                req_ack;
    logic                expired;
    logic                retire;

    assign cls = op_class(4'(op_q));

    // Only the ack belonging to the current wait state counts
    assign waiting = (state == FETCH) || (state == MEM);
    assign req_ack = ((state == FETCH) && imem_ack)
                  || ((state == MEM) && dmem_ack);

    seq_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!waiting || req_ack),
        .enable  (waiting && !req_ack),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Opcode is captured from the IR only during DECODE
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= '0;
        end else if (state == DECODE) begin
            op_q <= opcode;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= '0;
        end else if (retire) begin
            retired_count <= retired_count + 1'b1;
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        state_n    = state;
        retire     = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_INC;
        alu_op     = ALU_FUNC;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        fault      = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_n = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_INC;
                    state_n  = DECODE;
                end else if (expired) begin
                    state_n = FAULT;
                end
            end
            DECODE: begin
                state_n = EXEC;
            end
            EXEC: begin
                case (cls)
                    C_LW, C_SW: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADD;
                        state_n = MEM;
                    end
                    C_BEQ: begin
                        alu_op   = ALU_SUB;
                        pc_src   = PC_BRANCH;
                        pc_write = zero;
                        retire   = 1'b1;
                    end
                    C_BNE: begin
                        alu_op   = ALU_SUB;
                        pc_src   = PC_BRANCH;
                        pc_write = ~zero;
                        retire   = 1'b1;
                    end
                    C_J: begin
                        pc_src   = PC_JUMP;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    default: begin
                        reg_dst = 1'b1;
                        alu_op  = ALU_FUNC;
                        state_n = WB;
                    end
                endcase
            end
            MEM: begin
                alu_src    = 1'b1;
                alu_op     = ALU_ADD;
                dmem_read  = (cls == C_LW);
                dmem_write = (cls != C_LW);
                if (dmem_ack) begin
                    if (cls == C_LW) state_n = WB;
                    else             retire  = 1'b1;
                end else if (expired) begin
                    state_n = FAULT;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls == C_LW);
                reg_dst    = (cls != C_LW);
                retire     = 1'b1;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (retire) state_n = run ? FETCH : IDLE;
    end

    assign busy = (state != IDLE) && (state != FAULT);

endmodule
